sevenseg_scan_decoder: RTL and testbench
========================================

SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive equal samples required before a capture; legal range 1..255.
REQ-002 CLK100MHZ  in  1  single system clock; all state updates on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 AN  in  8  digit enables, active-low, from a multiplexed 8-digit display driver.
REQ-005 CA, CB, CC, CD, CE, CF, CG, DP  in  1 each  segment lines, active-low.
REQ-006 SEG_CAP  out  64  captured segments per digit, active-high; digit i occupies bits [8i+7:8i] = {DP,G,F,E,D,C,B,A}.
REQ-007 HEX  out  32  decoded hex value per digit; digit i occupies bits [4i+3:4i].
REQ-008 HEX_VALID  out  8  bit i is high when SEG_CAP digit i matches a hex glyph.
REQ-009 FRAME_VALID  out  1  single-cycle pulse when all 8 digits have been captured since the previous pulse or since reset.
REQ-010 ERROR  out  1  sticky flag: a stable sample had more than one AN bit low.

Function
REQ-011 Sample vector S = {AN, CA..CG, DP} (16 bits) is registered every cycle with no extra synchronizer stage; inputs share the CLK100MHZ domain.
REQ-012 State machine states: SETTLE and HOLD; 8-bit stability counter CNT.
REQ-013 Live input != S at an edge: S loads the input, CNT <= 0, state <= SETTLE; this applies in both states.
REQ-014 Live input == S in SETTLE with CNT == STABLE_CYCLES-1: perform a capture and move to HOLD; otherwise CNT increments.
REQ-015 Live input == S in HOLD: no action, no further capture until the input changes.
REQ-016 Latency: after the input changes and then holds, capture outputs update on the (STABLE_CYCLES+1)-th rising edge, counting the edge that loads S as the first.
REQ-017 Capture with exactly one AN bit low (index i): SEG_CAP[i] <= ~{DP,CG..CA}; HEX[i] and HEX_VALID[i] update from the decode; seen-mask bit i is set; all other digits are unchanged.
REQ-018 Capture with AN == 8'hFF (blanked): no output or mask change.
REQ-019 Capture with two or more AN bits low: ERROR <= 1; no SEG_CAP, HEX or mask change.
REQ-020 Decode uses the 7 active-high bits {G..A} (A = bit 0) and ignores DP: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-021 A pattern not in the decode table sets HEX[i] = 0 and HEX_VALID[i] = 0, and SEG_CAP[i] still records the raw pattern.
REQ-022 Seen mask (8 bits): when a capture would make the mask 8'hFF, FRAME_VALID is high for exactly the cycle after that edge and the mask clears to 0 on the same edge.
REQ-023 Recapturing an already-seen digit before the frame completes updates its data, leaves the mask unchanged, and does not pulse FRAME_VALID.
REQ-024 Glitches shorter than STABLE_CYCLES+1 edges never cause a capture; each glitch restarts the count per REQ-013.

Reset
REQ-025 RESET high at an edge: S <= 16'hFFFF, CNT <= 0, state <= HOLD, mask <= 0, SEG_CAP <= 0, HEX <= 0, HEX_VALID <= 0, FRAME_VALID <= 0, ERROR <= 0.
REQ-026 RESET takes priority over capture at the same edge; reset mid-frame discards partial mask progress.
REQ-027 After reset, the first capture requires an input change from 16'hFFFF followed by a stable period.
REQ-028 ERROR clears only on RESET.

Verification
REQ-029 Reset, then AN = FE with segments for '3' (active-low 0x30) held 10 cycles -> SEG_CAP[7:0] = 0x4F, HEX[3:0] = 3, HEX_VALID[0] = 1, update on the 5th edge with STABLE_CYCLES = 4.
REQ-030 Scan digits 0..7 showing 0..7, each held 6 cycles -> exactly one FRAME_VALID pulse after digit 7; HEX = 0x76543210; HEX_VALID = FF.
REQ-031 Digit 2 with a single-segment spinner pattern (A only) -> SEG_CAP[23:16] = 0x01, HEX_VALID[2] = 0, HEX[11:8] = 0.
REQ-032 AN = FC held stable -> ERROR = 1 and persists after AN returns to one-hot; no capture occurs; cleared only by RESET.
REQ-033 Segment toggles every 3 cycles on digit 1 for 30 cycles -> no capture, SEG_CAP unchanged; then held stable -> single capture.
REQ-034 RESET asserted after 5 of 8 digits captured -> all outputs 0; a full 8-digit scan is then needed before FRAME_VALID pulses.

Source files
------------

// File: rtl/sevenseg_scan_decoder.sv
// Recovers per-digit segment patterns and hex values by watching the scan lines
// of a multiplexed 8-digit seven-segment display driver in the same clock domain.
module sevenseg_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        CLK100MHZ,
   input  logic        RESET,
   input  logic [7:0]  AN,
   input  logic        CA,
   input  logic        CB,
   input  logic        CC,
   input  logic        CD,
   input  logic        CE,
   input  logic        CF,
   input  logic        CG,
   input  logic        DP,
   output logic [63:0] SEG_CAP,
   output logic [31:0] HEX,
   output logic [7:0]  HEX_VALID,
   output logic        FRAME_VALID,
   output logic        ERROR
);

   localparam logic [0:0] SETTLE = 1'b0;
   localparam logic [0:0] HOLD   = 1'b1;

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   logic [15:0]      live;
   logic [15:0]      sample;
   logic [7:0]       cnt;
   logic [0:0]       state;
   logic [7:0]       seen;
   logic [7:0]       seen_next;
   logic [7:0][7:0]  seg_cap;
   logic [7:0][3:0]  hex;
   logic [7:0]       hex_valid;
   logic             frame_valid;
   logic             error;

   logic [7:0]       an_low;
   logic [7:0]       seg_hi;
   logic             one_hot;
   logic             multi;
   logic [2:0]       digit;
   logic [3:0]       dec_hex;
   logic             dec_valid;

   assign live = {AN, CA, CB, CC, CD, CE, CF, CG, DP};

   // Everything a capture needs is taken from the held sample, which equals the live input when a capture fires.
   assign an_low = ~sample[15:8];
   assign seg_hi = {~sample[0], ~sample[1], ~sample[2], ~sample[3],
                    ~sample[4], ~sample[5], ~sample[6], ~sample[7]};

   assign one_hot = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
   assign multi   = (an_low != 8'd0) && !one_hot;

   always_comb begin
      digit = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (an_low[i]) begin
            digit = 3'(i);
         end
      end
   end

   assign seen_next = seen | (8'd1 << digit);

   always_comb begin
      dec_hex   = 4'h0;
      dec_valid = 1'b1;
      case (seg_hi[6:0])
         7'h3F:   dec_hex = 4'h0;
         7'h06:   dec_hex = 4'h1;
         7'h5B:   dec_hex = 4'h2;
         7'h4F:   dec_hex = 4'h3;
         7'h66:   dec_hex = 4'h4;
         7'h6D:   dec_hex = 4'h5;
         7'h7D:   dec_hex = 4'h6;
         7'h07:   dec_hex = 4'h7;
         7'h7F:   dec_hex = 4'h8;
         7'h6F:   dec_hex = 4'h9;
         7'h77:   dec_hex = 4'hA;
         7'h7C:   dec_hex = 4'hB;
         7'h39:   dec_hex = 4'hC;
         7'h5E:   dec_hex = 4'hD;
         7'h79:   dec_hex = 4'hE;
         7'h71:   dec_hex = 4'hF;
         default: dec_valid = 1'b0;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RESET) begin
         sample      <= 16'hFFFF;
         cnt         <= 8'd0;
         state       <= HOLD;
         seen        <= 8'd0;
         seg_cap     <= '0;
         hex         <= '0;
         hex_valid   <= 8'd0;
         frame_valid <= 1'b0;
         error       <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (live != sample) begin
            sample <= live;
            cnt    <= 8'd0;
            state  <= SETTLE;
         end else if (state == SETTLE) begin
            if (cnt == CNT_LAST) begin
               state <= HOLD;
               if (one_hot) begin
                  seg_cap[digit]   <= seg_hi;
                  hex[digit]       <= dec_hex;
                  hex_valid[digit] <= dec_valid;
                  // Completing the set of eight digits starts a new frame immediately.
                  if (seen_next == 8'hFF) begin
                     seen        <= 8'd0;
                     frame_valid <= 1'b1;
                  end else begin
                     seen <= seen_next;
                  end
               end else if (multi) begin
                  error <= 1'b1;
               end
            end else begin
               cnt <= cnt + 8'd1;
            end
         end
      end
   end

   assign SEG_CAP     = seg_cap;
   assign HEX         = hex;
   assign HEX_VALID   = hex_valid;
   assign FRAME_VALID = frame_valid;
   assign ERROR       = error;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: table of digit captures plus hand-written
// sequences for latency, glitches, blanking, multi-digit errors and mid-frame reset.
module tb_sevenseg_scan_decoder;

   logic        CLK100MHZ;
   logic        RESET;
   logic [7:0]  AN;
   logic        CA, CB, CC, CD, CE, CF, CG, DP;
   logic [63:0] SEG_CAP;
   logic [31:0] HEX;
   logic [7:0]  HEX_VALID;
   logic        FRAME_VALID;
   logic        ERROR;

   sevenseg_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .CLK100MHZ   (CLK100MHZ),
      .RESET       (RESET),
      .AN          (AN),
      .CA          (CA),
      .CB          (CB),
      .CC          (CC),
      .CD          (CD),
      .CE          (CE),
      .CF          (CF),
      .CG          (CG),
      .DP          (DP),
      .SEG_CAP     (SEG_CAP),
      .HEX         (HEX),
      .HEX_VALID   (HEX_VALID),
      .FRAME_VALID (FRAME_VALID),
      .ERROR       (ERROR)
   );

   initial CLK100MHZ = 1'b0;
   always #5 CLK100MHZ = ~CLK100MHZ;

   typedef struct {
      logic [7:0] an;
      logic [6:0] glyph;
      logic       dp;
      int         digit;
      logic [3:0] hex;
      logic       hv;
      int         pulses;
   } vec_t;

   vec_t        vecs [16];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_seg = '0;
   logic [31:0] exp_hex = '0;
   logic [7:0]  exp_hv  = '0;
   int          pulses;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Inputs change only right after a falling edge so the DUT sees them settled at the next rising edge.
   task automatic drive_inputs(input logic [7:0] an, input logic [6:0] glyph, input logic dp);
      AN = an;
      {CG, CF, CE, CD, CC, CB, CA} = ~glyph;
      DP = ~dp;
   endtask

   task automatic hold_cycles(input int n, output int seen_pulses);
      seen_pulses = 0;
      repeat (n) begin
         @(negedge CLK100MHZ);
         if (FRAME_VALID) seen_pulses++;
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] an, input logic [6:0] glyph, input logic dp,
                                 input int digit, input logic [3:0] hx, input logic hv,
                                 output int seen_pulses);
      drive_inputs(an, glyph, dp);
      hold_cycles(6, seen_pulses);
      if (digit >= 0) begin
         exp_seg[digit*8 +: 8] = {dp, glyph};
         exp_hex[digit*4 +: 4] = hx;
         exp_hv[digit]         = hv;
      end
   endtask

   task automatic check_output(input string name);
      check({name, " seg_cap"}, SEG_CAP, exp_seg);
      check({name, " hex"}, {32'd0, HEX}, {32'd0, exp_hex});
      check({name, " hex_valid"}, {56'd0, HEX_VALID}, {56'd0, exp_hv});
   endtask

   task automatic run_vector(input int idx);
      apply_stimulus(vecs[idx].an, vecs[idx].glyph, vecs[idx].dp, vecs[idx].digit,
                     vecs[idx].hex, vecs[idx].hv, pulses);
      check_output($sformatf("vec%0d", idx));
      check($sformatf("vec%0d frame_pulses", idx), 64'(pulses), 64'(vecs[idx].pulses));
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      drive_inputs(8'hFF, 7'h00, 1'b0);
      repeat (2) @(negedge CLK100MHZ);
      RESET = 1'b0;
      exp_seg = '0;
      exp_hex = '0;
      exp_hv  = '0;
   endtask

   task automatic check_all_zero(input string name);
      check_output(name);
      check({name, " frame_valid"}, {63'd0, FRAME_VALID}, 64'd0);
      check({name, " error"}, {63'd0, ERROR}, 64'd0);
   endtask

   initial begin
      vecs[0]  = '{8'hFE, 7'h3F, 1'b0, 0, 4'h0, 1'b1, 0};
      vecs[1]  = '{8'hFD, 7'h06, 1'b0, 1, 4'h1, 1'b1, 0};
      vecs[2]  = '{8'hFB, 7'h5B, 1'b0, 2, 4'h2, 1'b1, 0};
      vecs[3]  = '{8'hF7, 7'h4F, 1'b0, 3, 4'h3, 1'b1, 0};
      vecs[4]  = '{8'hEF, 7'h66, 1'b0, 4, 4'h4, 1'b1, 0};
      vecs[5]  = '{8'hDF, 7'h6D, 1'b1, 5, 4'h5, 1'b1, 0};
      vecs[6]  = '{8'hBF, 7'h7D, 1'b0, 6, 4'h6, 1'b1, 0};
      vecs[7]  = '{8'h7F, 7'h07, 1'b0, 7, 4'h7, 1'b1, 1};
      vecs[8]  = '{8'hFE, 7'h7F, 1'b0, 0, 4'h8, 1'b1, 0};
      vecs[9]  = '{8'hFD, 7'h6F, 1'b0, 1, 4'h9, 1'b1, 0};
      vecs[10] = '{8'hFB, 7'h77, 1'b0, 2, 4'hA, 1'b1, 0};
      vecs[11] = '{8'hF7, 7'h7C, 1'b0, 3, 4'hB, 1'b1, 0};
      vecs[12] = '{8'hEF, 7'h39, 1'b0, 4, 4'hC, 1'b1, 0};
      vecs[13] = '{8'hDF, 7'h5E, 1'b0, 5, 4'hD, 1'b1, 0};
      vecs[14] = '{8'hBF, 7'h79, 1'b0, 6, 4'hE, 1'b1, 0};
      vecs[15] = '{8'h7F, 7'h71, 1'b0, 7, 4'hF, 1'b1, 1};

      RESET = 1'b1;
      drive_inputs(8'hFF, 7'h00, 1'b0);
      @(negedge CLK100MHZ);
      do_reset();
      check_all_zero("reset");

      // A '3' on digit 0 must appear on exactly the fifth rising edge after the change.
      drive_inputs(8'hFE, 7'h4F, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge CLK100MHZ);
         check($sformatf("latency edge%0d", k), {56'd0, SEG_CAP[7:0]},
               (k < 5) ? 64'h00 : 64'h4F);
      end
      hold_cycles(5, pulses);
      exp_seg[7:0] = 8'h4F;
      exp_hex[3:0] = 4'h3;
      exp_hv[0]    = 1'b1;
      check_output("latency hold");

      for (int i = 0; i < 8; i++) run_vector(i);
      check("frame1 seg_cap const", SEG_CAP, 64'h077D_ED66_4F5B_063F);
      check("frame1 hex const", {32'd0, HEX}, 64'h7654_3210);
      check("frame1 hex_valid const", {56'd0, HEX_VALID}, 64'hFF);

      for (int i = 8; i < 16; i++) run_vector(i);
      check("frame2 hex const", {32'd0, HEX}, 64'hFEDC_BA98);

      apply_stimulus(8'hFB, 7'h01, 1'b0, 2, 4'h0, 1'b0, pulses);
      check_output("spinner");
      check("spinner seg byte", {56'd0, SEG_CAP[23:16]}, 64'h01);
      check("spinner hex const", {32'd0, HEX}, 64'hFEDC_B098);
      check("spinner hex_valid const", {56'd0, HEX_VALID}, 64'hFB);

      apply_stimulus(8'hFF, 7'h7F, 1'b0, -1, 4'h0, 1'b0, pulses);
      check_output("blank");
      check("blank frame_pulses", 64'(pulses), 64'd0);

      for (int g = 0; g < 10; g++) begin
         drive_inputs(8'hFD, (g % 2 == 0) ? 7'h06 : 7'h07, 1'b0);
         hold_cycles(3, pulses);
         check($sformatf("glitch%0d seg_cap", g), SEG_CAP, exp_seg);
      end
      apply_stimulus(8'hFD, 7'h07, 1'b0, 1, 4'h7, 1'b1, pulses);
      check_output("glitch settled");
      check("glitch settled hex const", {32'd0, HEX}, 64'hFEDC_B078);

      apply_stimulus(8'hFC, 7'h3F, 1'b0, -1, 4'h0, 1'b0, pulses);
      check_output("multi low");
      check("multi low error", {63'd0, ERROR}, 64'd1);
      apply_stimulus(8'hFE, 7'h06, 1'b0, 0, 4'h1, 1'b1, pulses);
      check_output("after multi");
      check("error sticky", {63'd0, ERROR}, 64'd1);

      do_reset();
      check_all_zero("reset after error");

      for (int i = 0; i < 5; i++) run_vector(i);
      do_reset();
      check_all_zero("reset mid frame");
      for (int i = 0; i < 8; i++) run_vector(i);
      check("rescan hex const", {32'd0, HEX}, 64'h7654_3210);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
